// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (req 0) and branch/AGU (req 1); round-robin with optional lock.
// Grant and ALU mux are combinational; the result is registered and returned one cycle after the transfer.
module alu_share_arbiter #(
    parameter int         LOCK_MAX   = 8,
    parameter int         FIRST_PRIO = 0,
    parameter logic [2:0] IDLE_OP    = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req0Valid,
    output logic        Req0Ready,
    input  logic [2:0]  Req0Op,
    input  logic [31:0] Req0In1,
    input  logic [31:0] Req0In2,
    input  logic [4:0]  Req0Shamt,
    input  logic        Req0Lock,
    input  logic        Req1Valid,
    output logic        Req1Ready,
    input  logic [2:0]  Req1Op,
    input  logic [31:0] Req1In1,
    input  logic [31:0] Req1In2,
    input  logic [4:0]  Req1Shamt,
    input  logic        Req1Lock,
    output logic [2:0]  AluOP,
    output logic [31:0] AluInput1,
    output logic [31:0] AluInput2,
    output logic [4:0]  AluShiftAmount,
    input  logic [31:0] AluResult,
    input  logic        AluOverflow,
    output logic        Resp0Valid,
    output logic        Resp1Valid,
    output logic [31:0] RespResult,
    output logic        RespOverflow,
    output logic [1:0]  LockOwner
);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);
    // last_grant names the requester that won the previous transfer; reset so FIRST_PRIO wins the first tie.
    localparam logic       LAST_RST   = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    logic [1:0] state, state_nxt;
    logic [3:0] lock_cnt, lock_cnt_nxt;
    logic       last_grant;
    logic       gnt0, gnt1;
    logic       xfer;
    logic       sel_lock;
    logic [3:0] cnt_inc;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ST_LOCK0: gnt0 = Req0Valid;
            ST_LOCK1: gnt1 = Req1Valid;
            default: begin
                if (Req0Valid && Req1Valid) begin
                    gnt0 = last_grant;
                    gnt1 = ~last_grant;
                end else begin
                    gnt0 = Req0Valid;
                    gnt1 = Req1Valid;
                end
            end
        endcase
        gnt0 = gnt0 & rst_n;
        gnt1 = gnt1 & rst_n;
    end

    assign Req0Ready = gnt0;
    assign Req1Ready = gnt1;
    assign xfer      = gnt0 | gnt1;
    assign sel_lock  = gnt1 ? Req1Lock : Req0Lock;
    assign cnt_inc   = lock_cnt + 4'd1;

    always_comb begin
        AluOP          = IDLE_OP;
        AluInput1      = 32'd0;
        AluInput2      = 32'd0;
        AluShiftAmount = 5'd0;
        if (gnt1) begin
            AluOP          = Req1Op;
            AluInput1      = Req1In1;
            AluInput2      = Req1In2;
            AluShiftAmount = Req1Shamt;
        end else if (gnt0) begin
            AluOP          = Req0Op;
            AluInput1      = Req0In1;
            AluInput2      = Req0In2;
            AluShiftAmount = Req0Shamt;
        end
    end

    // Entry counts as the first locked transfer; with LOCK_MAX=1 the lock is released on entry.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (xfer) begin
            if (state == ST_ARB) begin
                if (sel_lock && (LOCK_MAX_C > 4'd1)) begin
                    state_nxt    = gnt1 ? ST_LOCK1 : ST_LOCK0;
                    lock_cnt_nxt = 4'd1;
                end
            end else if (!sel_lock || (cnt_inc == LOCK_MAX_C)) begin
                state_nxt    = ST_ARB;
                lock_cnt_nxt = 4'd0;
            end else begin
                lock_cnt_nxt = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_ARB;
            lock_cnt     <= 4'd0;
            last_grant   <= LAST_RST;
            Resp0Valid   <= 1'b0;
            Resp1Valid   <= 1'b0;
            RespResult   <= 32'd0;
            RespOverflow <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            Resp0Valid <= gnt0;
            Resp1Valid <= gnt1;
            if (xfer) begin
                last_grant   <= gnt1;
                RespResult   <= AluResult;
                RespOverflow <= AluOverflow;
            end
        end
    end

    assign LockOwner = {state == ST_LOCK1, state == ST_LOCK0};

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int         LOCK_MAX   = 8;
    localparam int         FIRST_PRIO = 0;
    localparam logic [2:0] IDLE_OP    = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v  [2];
    logic [2:0]  op [2];
    logic [31:0] a  [2];
    logic [31:0] b  [2];
    logic [4:0]  sh [2];
    logic        lk [2];

    logic        rdy0, rdy1;
    logic [2:0]  alu_op;
    logic [31:0] alu_in1, alu_in2, alu_res, resp_res;
    logic [4:0]  alu_sh;
    logic        alu_ovf, resp0_vld, resp1_vld, resp_ovf;
    logic [1:0]  lock_owner;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_owner;
    int          m_cnt;
    int          m_last;
    logic        m_rv [2];
    logic [31:0] m_res;
    logic        m_ovf;

    always #5 clk = ~clk;

    alu_share_arbiter #(.LOCK_MAX(LOCK_MAX), .FIRST_PRIO(FIRST_PRIO), .IDLE_OP(IDLE_OP)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0Valid(v[0]), .Req0Ready(rdy0), .Req0Op(op[0]), .Req0In1(a[0]), .Req0In2(b[0]),
        .Req0Shamt(sh[0]), .Req0Lock(lk[0]),
        .Req1Valid(v[1]), .Req1Ready(rdy1), .Req1Op(op[1]), .Req1In1(a[1]), .Req1In2(b[1]),
        .Req1Shamt(sh[1]), .Req1Lock(lk[1]),
        .AluOP(alu_op), .AluInput1(alu_in1), .AluInput2(alu_in2), .AluShiftAmount(alu_sh),
        .AluResult(alu_res), .AluOverflow(alu_ovf),
        .Resp0Valid(resp0_vld), .Resp1Valid(resp1_vld), .RespResult(resp_res),
        .RespOverflow(resp_ovf), .LockOwner(lock_owner)
    );

    function automatic logic [32:0] alu_f(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s);
        logic [31:0] r;
        logic        o;
        r = 32'd0;
        o = 1'b0;
        case (f)
            3'b010: begin r = x + y; o = (x[31] == y[31]) && (r[31] != x[31]); end
            3'b110: begin r = x - y; o = (x[31] != y[31]) && (r[31] != x[31]); end
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b011: r = x << s;
            3'b111: r = {31'd0, $signed(x) < $signed(y)};
            default: r = 32'd0;
        endcase
        return {o, r};
    endfunction

    // the bench plays the role of the combinational ALU
    always_comb {alu_ovf, alu_res} = alu_f(alu_op, alu_in1, alu_in2, alu_sh);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1 - FIRST_PRIO;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        m_res   = 32'd0;
        m_ovf   = 1'b0;
    endtask

    // Check the current cycle against the model, then advance the model over the coming edge.
    task automatic step();
        int          g;
        logic [32:0] r;
        #1;
        if (m_owner >= 0)    g = v[m_owner] ? m_owner : -1;
        else if (v[0] && v[1]) g = 1 - m_last;
        else if (v[0])       g = 0;
        else if (v[1])       g = 1;
        else                 g = -1;

        check("ready0", 32'(rdy0), 32'(g == 0));
        check("ready1", 32'(rdy1), 32'(g == 1));
        check("alu_op", 32'(alu_op), (g < 0) ? 32'(IDLE_OP) : 32'(op[g]));
        check("alu_in1", alu_in1, (g < 0) ? 32'd0 : a[g]);
        check("alu_in2", alu_in2, (g < 0) ? 32'd0 : b[g]);
        check("alu_sh", 32'(alu_sh), (g < 0) ? 32'd0 : 32'(sh[g]));
        check("resp0_vld", 32'(resp0_vld), 32'(m_rv[0]));
        check("resp1_vld", 32'(resp1_vld), 32'(m_rv[1]));
        check("resp_res", resp_res, m_res);
        check("resp_ovf", 32'(resp_ovf), 32'(m_ovf));
        check("lock_owner", 32'(lock_owner), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));

        m_rv[0] = (g == 0);
        m_rv[1] = (g == 1);
        if (g >= 0) begin
            r = alu_f(op[g], a[g], b[g], sh[g]);
            m_ovf = r[32];
            m_res = r[31:0];
            if (m_owner < 0) begin
                if (lk[g] && LOCK_MAX > 1) begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end else begin
                m_cnt++;
                if (!lk[g] || m_cnt == LOCK_MAX) m_owner = -1;
            end
            m_last = g;
        end
    endtask

    task automatic drive(input logic v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic l0, input logic v1, input logic [2:0] o1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic l1);
        @(negedge clk);
        v[0] = v0; op[0] = o0; a[0] = a0; b[0] = b0; sh[0] = 5'd0; lk[0] = l0;
        v[1] = v1; op[1] = o1; a[1] = a1; b[1] = b1; sh[1] = 5'd0; lk[1] = l1;
        step();
    endtask

    task automatic idle();
        drive(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    logic [2:0] ops [6];

    initial begin
        ops[0] = 3'b010; ops[1] = 3'b110; ops[2] = 3'b000;
        ops[3] = 3'b001; ops[4] = 3'b011; ops[5] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; op[i] = 0; a[i] = 0; b[i] = 0; sh[i] = 0; lk[i] = 0;
        end
        model_reset();
        #1;
        check("rst_ready0", 32'(rdy0), 32'd0);
        check("rst_lock_owner", 32'(lock_owner), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();

        // single requester add
        drive(1, 3'b010, 5, 7, 0, 0, 3'b000, 0, 0, 0);
        idle();
        check("t1_result", resp_res, 32'd12);

        // tie alternation
        for (int i = 0; i < 4; i++) drive(1, 3'b110, 9, 4, 0, 1, 3'b000, 32'hF0, 32'h3C, 0);
        idle();

        // signed overflow through requester 1
        drive(0, 3'b000, 0, 0, 0, 1, 3'b010, 32'h7FFFFFFF, 1, 0);
        idle();
        check("t3_ovf", 32'(resp_ovf), 32'd1);

        // lock by requester 0 for 3 transfers, then release
        for (int i = 0; i < 3; i++) drive(1, 3'b001, i, 8, 1, 1, 3'b000, 1, 1, 0);
        drive(1, 3'b001, 3, 8, 0, 1, 3'b000, 1, 1, 0);
        drive(1, 3'b001, 4, 8, 0, 1, 3'b000, 1, 1, 0);
        idle();

        // forced release after LOCK_MAX transfers
        for (int i = 0; i < LOCK_MAX + 3; i++) drive(1, 3'b010, i, 1, 0, 1, 3'b011, 1, 2, 1);
        idle();

        // reset in the middle of a lock with a response pending
        drive(1, 3'b010, 1, 1, 1, 1, 3'b010, 2, 2, 0);
        drive(1, 3'b010, 3, 3, 1, 1, 3'b010, 4, 4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_resp0", 32'(resp0_vld), 32'd0);
        check("mid_rst_res", resp_res, 32'd0);
        check("mid_rst_lock", 32'(lock_owner), 32'd0);
        check("mid_rst_ready0", 32'(rdy0), 32'd0);
        v[0] = 0; v[1] = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1, 3'b000, 32'hFF, 32'h0F, 0, 1, 3'b001, 1, 2, 0);
        idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                v[k]  = ($urandom_range(0, 3) != 0);
                op[k] = ops[$urandom_range(0, 5)];
                a[k]  = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
                b[k]  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
                sh[k] = 5'($urandom);
                lk[k] = ($urandom_range(0, 2) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
